// File: rtl/uart_pkg.sv
// Shared definitions for the parameterised UART transmitter.
//   uart_state_e : transmitter FSM states
//   PAR_*        : values of the PARITY parameter
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PAR,
    STOP
  } uart_state_e;

  localparam int PAR_NONE = 0;
  localparam int PAR_EVEN = 1;
  localparam int PAR_ODD  = 2;

endpackage

// File: rtl/uart_baud_cnt.sv
// Bit-period counter: counts CLKS_PER_BIT cycles per bit while enabled.
//   clk_sis : system clock
//   rst     : synchronous active-high reset
//   clear   : force the count back to the start of a period
//   enable  : count this cycle
//   tick    : high in the last cycle of each period
module uart_baud_cnt #(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic clk_sis,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic tick
);

  localparam int            CW   = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  // Wrapping to zero on the last cycle is the reload for the next bit/state.
  always_comb begin
    cnt_d = cnt_q;
    if (clear)       cnt_d = '0;
    else if (enable) cnt_d = (cnt_q == LAST) ? '0 : cnt_q + CW'(1);
  end

  always_ff @(posedge clk_sis) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign tick = enable && !clear && (cnt_q == LAST);

endmodule

// File: rtl/uart_tx_param.sv
// Parameterised UART transmitter: start bit, DATA_W data bits LSB first,
// optional even/odd parity, STOP_BITS stop bits.
//   clk_sis    : system clock
//   rst        : synchronous active-high reset
//   tx_data    : word to send, captured at the valid/ready handshake
//   tx_valid   : tx_data is valid
//   tx_ready   : block can accept a word (IDLE only)
//   tx_line    : registered serial output, idle high
//   busy       : frame in progress
//   frame_done : pulse in the last cycle of the final stop bit
module uart_tx_param
  import uart_pkg::*;
#(
  parameter int DATA_W       = 8,
  parameter int CLKS_PER_BIT = 4,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic              clk_sis,
  input  logic              rst,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic              tx_line,
  output logic              busy,
  output logic              frame_done
);

  localparam int            BW        = $clog2(DATA_W);
  localparam logic [BW-1:0] LAST_BIT  = BW'(DATA_W - 1);
  localparam logic          LAST_STOP = 1'(STOP_BITS - 1);
  localparam logic          PAR_INV   = (PARITY == PAR_ODD);

  uart_state_e       state_q, state_d;
  logic [BW-1:0]     bit_q, bit_d;
  logic              stop_q, stop_d;
  logic [DATA_W-1:0] shreg_q, shreg_d;
  logic              par_q, par_d;
  logic              line_q, line_d;
  logic              ready_q, ready_d;
  logic              tick;

  uart_baud_cnt #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk_sis(clk_sis),
    .rst    (rst),
    .clear  (state_q == IDLE),
    .enable (state_q != IDLE),
    .tick   (tick)
  );

  // The line register is loaded with the value of the state being entered,
  // so it changes exactly on bit boundaries.
  always_comb begin
    state_d = state_q;
    bit_d   = bit_q;
    stop_d  = stop_q;
    shreg_d = shreg_q;
    par_d   = par_q;
    line_d  = line_q;
    ready_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        line_d = 1'b1;
        if (tx_valid && ready_q) begin
          state_d = START;
          shreg_d = tx_data;
          // Parity is fixed at capture; the shifter destroys the word later.
          par_d   = (^tx_data) ^ PAR_INV;
          bit_d   = '0;
          stop_d  = 1'b0;
          line_d  = 1'b0;
        end else begin
          ready_d = 1'b1;
        end
      end
      START: begin
        if (tick) begin
          state_d = DATA;
          line_d  = shreg_q[0];
        end
      end
      DATA: begin
        if (tick) begin
          if (bit_q == LAST_BIT) begin
            if (PARITY != PAR_NONE) begin
              state_d = PAR;
              line_d  = par_q;
            end else begin
              state_d = STOP;
              line_d  = 1'b1;
            end
          end else begin
            bit_d   = bit_q + BW'(1);
            shreg_d = shreg_q >> 1;
            line_d  = shreg_q[1];
          end
        end
      end
      PAR: begin
        if (tick) begin
          state_d = STOP;
          line_d  = 1'b1;
        end
      end
      STOP: begin
        line_d = 1'b1;
        if (tick) begin
          if (stop_q == LAST_STOP) begin
            state_d = IDLE;
            ready_d = 1'b1;
            bit_d   = '0;
            stop_d  = 1'b0;
          end else begin
            stop_d = 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
        line_d  = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk_sis) begin
    if (rst) begin
      state_q <= IDLE;
      bit_q   <= '0;
      stop_q  <= 1'b0;
      shreg_q <= '0;
      par_q   <= 1'b0;
      line_q  <= 1'b1;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      bit_q   <= bit_d;
      stop_q  <= stop_d;
      shreg_q <= shreg_d;
      par_q   <= par_d;
      line_q  <= line_d;
      ready_q <= ready_d;
    end
  end

  assign tx_ready   = ready_q;
  assign tx_line    = line_q;
  assign busy       = (state_q != IDLE);
  // Gated by rst so an abort landing on the last stop cycle never pulses.
  assign frame_done = (state_q == STOP) && tick && (stop_q == LAST_STOP) && !rst;

endmodule

// File: tb/tb_uart_tx_param.sv
// Directed bench for uart_tx_param with three configurations side by side:
//   0: DATA_W=8, even parity, 1 stop   1: DATA_W=8, odd parity, 1 stop
//   2: DATA_W=7, no parity, 2 stops
// Expected line levels are queued per cycle when a word is sent and popped
// as the frame is observed.
module tb_uart_tx_param;

  localparam int CPB = 4;

  logic clk_sis = 1'b0;
  always #5 clk_sis = ~clk_sis;

  logic       rst;
  logic       valid_v [3];
  logic [8:0] data_v  [3];
  logic       ready_v [3];
  logic       line_v  [3];
  logic       busy_v  [3];
  logic       done_v  [3];

  int cfg_dw   [3] = '{8, 8, 7};
  int cfg_par  [3] = '{1, 2, 0};
  int cfg_stop [3] = '{1, 1, 2};

  logic exp_q[$];
  int   n_assert = 0;
  int   n_fail   = 0;

  uart_tx_param #(.DATA_W(8), .CLKS_PER_BIT(CPB), .PARITY(1), .STOP_BITS(1)) u_even (
    .clk_sis(clk_sis), .rst(rst), .tx_data(data_v[0][7:0]), .tx_valid(valid_v[0]),
    .tx_ready(ready_v[0]), .tx_line(line_v[0]), .busy(busy_v[0]), .frame_done(done_v[0]));

  uart_tx_param #(.DATA_W(8), .CLKS_PER_BIT(CPB), .PARITY(2), .STOP_BITS(1)) u_odd (
    .clk_sis(clk_sis), .rst(rst), .tx_data(data_v[1][7:0]), .tx_valid(valid_v[1]),
    .tx_ready(ready_v[1]), .tx_line(line_v[1]), .busy(busy_v[1]), .frame_done(done_v[1]));

  uart_tx_param #(.DATA_W(7), .CLKS_PER_BIT(CPB), .PARITY(0), .STOP_BITS(2)) u_w7 (
    .clk_sis(clk_sis), .rst(rst), .tx_data(data_v[2][6:0]), .tx_valid(valid_v[2]),
    .tx_ready(ready_v[2]), .tx_line(line_v[2]), .busy(busy_v[2]), .frame_done(done_v[2]));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference frame built straight from the line format.
  task automatic push_frame(input int k, input logic [8:0] d);
    logic bits[$];
    logic p;
    p = 1'b0;
    bits.push_back(1'b0);
    for (int i = 0; i < cfg_dw[k]; i++) begin
      bits.push_back(d[i]);
      p = p ^ d[i];
    end
    if (cfg_par[k] == 1) bits.push_back(p);
    if (cfg_par[k] == 2) bits.push_back(~p);
    for (int i = 0; i < cfg_stop[k]; i++) bits.push_back(1'b1);
    foreach (bits[i])
      for (int c = 0; c < CPB; c++) exp_q.push_back(bits[i]);
  endtask

  // Called at a negedge in IDLE; leaves off at the negedge of the IDLE
  // cycle after the frame. nxt/keep are driven right after acceptance.
  task automatic run_frame(input int k, input logic [8:0] d, input logic [8:0] nxt,
                           input bit keep);
    int c;
    chk($sformatf("ready_pre[%0d]", k), ready_v[k], 1);
    data_v[k]  = d;
    valid_v[k] = 1'b1;
    push_frame(k, d);
    @(negedge clk_sis);
    data_v[k]  = nxt;
    valid_v[k] = keep;
    c = 0;
    while (exp_q.size() > 0) begin
      chk($sformatf("line[%0d] c%0d", k, c), line_v[k], exp_q.pop_front());
      chk($sformatf("done[%0d] c%0d", k, c), done_v[k], (exp_q.size() == 0));
      chk($sformatf("busy[%0d] c%0d", k, c), busy_v[k], 1);
      chk($sformatf("ready[%0d] c%0d", k, c), ready_v[k], 0);
      c++;
      @(negedge clk_sis);
    end
    chk($sformatf("idle_line[%0d]", k), line_v[k], 1);
    chk($sformatf("idle_ready[%0d]", k), ready_v[k], 1);
    chk($sformatf("idle_busy[%0d]", k), busy_v[k], 0);
    chk($sformatf("idle_done[%0d]", k), done_v[k], 0);
  endtask

  initial begin
    rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      valid_v[k] = 1'b0;
      data_v[k]  = '0;
    end
    repeat (3) @(negedge clk_sis);
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("rst_line[%0d]", k), line_v[k], 1);
      chk($sformatf("rst_ready[%0d]", k), ready_v[k], 0);
      chk($sformatf("rst_busy[%0d]", k), busy_v[k], 0);
      chk($sformatf("rst_done[%0d]", k), done_v[k], 0);
    end
    rst = 1'b0;
    chk("ready_at_release", ready_v[0], 0);
    @(negedge clk_sis);
    for (int k = 0; k < 3; k++) chk($sformatf("ready_after_rst[%0d]", k), ready_v[k], 1);

    // Even parity 0x5B: 44-cycle frame, parity bit 1.
    run_frame(0, 9'h05B, 9'h000, 1'b0);
    // Odd parity 0x42: parity bit 1.
    run_frame(1, 9'h042, 9'h000, 1'b0);
    // 7 data bits, two stop bits: 40 cycles, last 8 high.
    run_frame(2, 9'h07F, 9'h000, 1'b0);
    // Word changed right after acceptance must not leak into the frame.
    run_frame(0, 9'h0FF, 9'h000, 1'b0);
    // Valid held: second frame starts after exactly one idle cycle.
    run_frame(0, 9'h0A5, 9'h03C, 1'b1);
    run_frame(0, 9'h03C, 9'h000, 1'b0);

    // Abort mid-frame at cycle 10 (data bit 1 of 0xA5, which is 0).
    data_v[0]  = 9'h0A5;
    valid_v[0] = 1'b1;
    @(negedge clk_sis);
    valid_v[0] = 1'b0;
    repeat (10) @(negedge clk_sis);
    chk("abort_line_before", line_v[0], 0);
    rst = 1'b1;
    chk("abort_done_during", done_v[0], 0);
    @(negedge clk_sis);
    chk("abort_line", line_v[0], 1);
    chk("abort_busy", busy_v[0], 0);
    chk("abort_ready", ready_v[0], 0);
    chk("abort_done", done_v[0], 0);
    rst = 1'b0;
    @(negedge clk_sis);
    chk("abort_ready_after", ready_v[0], 1);
    chk("abort_line_after", line_v[0], 1);
    chk("abort_done_after", done_v[0], 0);

    // Reset wins over a handshake in the same cycle.
    data_v[0]  = 9'h055;
    valid_v[0] = 1'b1;
    rst        = 1'b1;
    @(negedge clk_sis);
    valid_v[0] = 1'b0;
    rst        = 1'b0;
    chk("prio_busy", busy_v[0], 0);
    chk("prio_ready", ready_v[0], 0);
    chk("prio_line", line_v[0], 1);
    @(negedge clk_sis);
    chk("prio_busy_after", busy_v[0], 0);
    chk("prio_ready_after", ready_v[0], 1);

    // Block still functional after the abort.
    run_frame(0, 9'h001, 9'h000, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_tx_param.md
UART_TX_PARAM -- requirements
Module: uart_tx_param

Interface
REQ-001 Parameter DATA_W, default 8, data bits per frame; legal range 5..9.
REQ-002 Parameter CLKS_PER_BIT, default 4, clk_sis cycles per bit; legal minimum 2.
REQ-003 Parameter PARITY, default 0, parity mode: 0 none, 1 even, 2 odd.
REQ-004 Parameter STOP_BITS, default 1, stop bits per frame; 1 or 2.
REQ-005 Clock and reset: one clock, clk_sis; reset is synchronous and active-high, rst.
REQ-006 clk_sis  input  1  system clock; all state updates on its rising edge.
REQ-007 rst  input  1  synchronous active-high reset.
REQ-008 tx_data  input  DATA_W  word to transmit; sampled only at handshake.
REQ-009 tx_valid  input  1  tx_data is valid.
REQ-010 tx_ready  output  1  block can accept a word.
REQ-011 tx_line  output  1  serial line; idle high.
REQ-012 busy  output  1  a frame is in progress.
REQ-013 frame_done  output  1  one-cycle pulse in the last cycle of the final stop bit.

Function
REQ-014 FSM states: IDLE, START, DATA, PAR, STOP.
REQ-015 Handshake: a word is accepted on a rising edge where tx_valid=1 and tx_ready=1; tx_ready=1 only in IDLE.
REQ-016 On acceptance, tx_data is latched into a shift register and the FSM enters START on the next cycle.
REQ-017 tx_valid while tx_ready=0 is ignored; tx_data changes after acceptance do not affect the frame in flight.
REQ-018 Each state holds for exactly CLKS_PER_BIT cycles, counted by a bit-period counter that reloads on every state or bit change.
REQ-019 START drives tx_line=0.
REQ-020 DATA shifts out DATA_W bits LSB first; a bit index counts 0..DATA_W-1, then the FSM leaves DATA.
REQ-021 PAR is entered only when PARITY!=0.
REQ-022 In PAR, tx_line carries XOR of the latched data bits for even parity, and its inverse for odd parity.
REQ-023 When PARITY=0, DATA goes directly to STOP.
REQ-024 STOP drives tx_line=1 for STOP_BITS*CLKS_PER_BIT cycles, asserts frame_done in its last cycle, then returns to IDLE.
REQ-025 Frame length in line cycles is CLKS_PER_BIT*(1+DATA_W+(PARITY!=0)+STOP_BITS).
REQ-026 Back-to-back frames are separated by exactly one IDLE cycle.
REQ-027 busy=1 in every state except IDLE.
REQ-028 tx_line is registered; it never glitches between bit periods.
REQ-029 Counters use ceil(log2) widths of their maxima; they never wrap during a frame.

Reset
REQ-030 While rst=1: state=IDLE, tx_line=1, tx_ready=0, busy=0, frame_done=0, and all counters and the shift register are 0.
REQ-031 tx_ready rises in the first cycle after rst deasserts.
REQ-032 rst asserted mid-frame aborts the frame on the next edge, drives tx_line=1, and does not pulse frame_done.
REQ-033 rst has priority over a simultaneous handshake.

Structure
REQ-034 A shared package uart_pkg holds the FSM state enum and the parity constants PAR_NONE, PAR_EVEN and PAR_ODD.
REQ-035 The bit-period counter is a sub-module uart_baud_cnt (parameter CLKS_PER_BIT; inputs clear and enable; output tick in the last cycle of each period).

Verification
REQ-036 Defaults with PARITY=1 (even), send 0x5B -> line reads 0, 1,1,0,1,1,0,1,0, parity 1, stop 1; each bit lasts 4 cycles; total 44 cycles; frame_done pulses once.
REQ-037 PARITY=2 (odd), send 0x42 -> data bits 0,1,0,0,0,0,1,0, then parity bit 1.
REQ-038 tx_valid held high with 0xA5 then 0x3C -> two frames separated by exactly one idle-high cycle; tx_ready high only in that cycle.
REQ-039 rst pulsed at cycle 10 of a frame -> tx_line=1 on the next edge, no frame_done pulse, tx_ready=1 one cycle after rst falls.
REQ-040 DATA_W=7, PARITY=0, STOP_BITS=2, send 0x7F -> frame of 1+7+2 bits = 40 cycles, with the last 8 cycles high.
REQ-041 tx_data changed to 0x00 one cycle after acceptance of 0xFF -> all eight data bits transmitted as 1.
